// File: rtl/sobol_pkg.sv
// Shared types and helpers for the multi-dimension Sobol generator.
package sobol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Result of the least-significant-zero search.
  // pos is meaningful only when all_ones is 0.
  typedef struct packed {
    logic       all_ones;
    logic [5:0] pos;
  } lsz_t;

  // Default direction vector V[k] = 1 << (width-1-k).
  // This makes every dimension a van der Corput sequence until it is reloaded.
  function automatic logic [63:0] vdc_vector(input int width, input int k);
    logic [63:0] one;
    one = 64'd1;
    return one << (width - 1 - k);
  endfunction

  // Priority encoder returning the position of the lowest 0 bit among the
  // low 'width' bits of n. The loop runs downward, so the lowest zero is the
  // last one assigned.
  function automatic lsz_t lsz_find(input logic [63:0] n, input int width);
    lsz_t r;
    r.all_ones = 1'b1;
    r.pos      = '0;
    for (int i = 63; i >= 0; i--) begin
      if ((i < width) && !n[i]) begin
        r.all_ones = 1'b0;
        r.pos      = 6'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sobol_dv_table.sv
// Direction-vector storage: DIMS x WIDTH vectors of WIDTH bits each.
// Provides one write port and one read-by-k port that returns V[d][k]
// for all dimensions at once.
module sobol_dv_table
  import sobol_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIMS  = 2,
  parameter int DIM_W = 1,
  parameter int BIT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DIM_W-1:0]      wr_dim,
  input  logic [BIT_W-1:0]      wr_bit,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [BIT_W-1:0]      rd_k,
  output logic [DIMS*WIDTH-1:0] rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DIMS; gi++) begin : g_dim
      logic [WIDTH-1:0] v_reg [WIDTH];
      logic             we_d;

      // A dimension select that matches no instance is silently dropped.
      assign we_d = we && (wr_dim == DIM_W'(gi));

      // Vector storage: van der Corput defaults on reset, single-entry writes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < WIDTH; k++) begin
            v_reg[k] <= WIDTH'(vdc_vector(WIDTH, k));
          end
        end else if (we_d) begin
          v_reg[wr_bit] <= wr_data;
        end
      end

      assign rd_data[gi*WIDTH +: WIDTH] = v_reg[rd_k];
    end
  endgenerate

endmodule

// File: rtl/sobol_multidim_gen.sv
// Multi-dimension Sobol point generator with Gray-code seek, optional point
// count and a valid/ready output stream.
module sobol_multidim_gen
  import sobol_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DIMS  = 2,
  localparam int DIM_W = (DIMS > 1) ? $clog2(DIMS) : 1,
  localparam int BIT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      start_index,
  input  logic [WIDTH-1:0]      num_points,
  input  logic                  dv_we,
  input  logic [DIM_W-1:0]      dv_dim,
  input  logic [BIT_W-1:0]      dv_bit,
  input  logic [WIDTH-1:0]      dv_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIMS*WIDTH-1:0] out_data,
  output logic [WIDTH-1:0]      out_index,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  state_t                state_reg, state_next;
  logic [WIDTH-1:0]      idx_reg;
  logic [WIDTH-1:0]      remaining_reg;
  logic [WIDTH-1:0]      out_index_reg;
  logic [DIMS*WIDTH-1:0] acc_reg;
  logic [DIMS*WIDTH-1:0] out_data_reg;
  logic [BIT_W:0]        k_reg;
  logic                  done_reg;
  logic                  wrap_reg;

  logic [DIMS*WIDTH-1:0] rd_data;
  logic [BIT_W-1:0]      rd_k;
  logic [WIDTH-1:0]      gray;
  logic                  g_bit;
  lsz_t                  lsz;
  logic                  seed_last;
  logic                  handshake;
  logic                  last_point;

  // The seek path XORs in V[d][k] for every set bit of gray(idx).
  assign gray  = idx_reg ^ (idx_reg >> 1);
  assign g_bit = gray[k_reg[BIT_W-1:0]];

  // Moving from n to n+1 flips gray bit c, where c is the lowest zero of n.
  assign lsz  = lsz_find(64'(out_index_reg), WIDTH);
  assign rd_k = (state_reg == SEED) ? k_reg[BIT_W-1:0] : BIT_W'(lsz.pos);

  // k runs 0..WIDTH-1 accumulating; the extra count k==WIDTH is the load cycle.
  assign seed_last  = (k_reg == (BIT_W+1)'(WIDTH));
  assign handshake  = (state_reg == RUN) && out_ready;
  assign last_point = (remaining_reg == WIDTH'(1));

  sobol_dv_table #(
    .WIDTH (WIDTH),
    .DIMS  (DIMS),
    .DIM_W (DIM_W),
    .BIT_W (BIT_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (dv_we && (state_reg == IDLE)),
    .wr_dim  (dv_dim),
    .wr_bit  (dv_bit),
    .wr_data (dv_data),
    .rd_k    (rd_k),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SEED;
      SEED:    if (seed_last) state_next = RUN;
      RUN:     if (handshake && last_point) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Datapath: latch the run parameters, accumulate the seed, step on handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      remaining_reg <= '0;
      out_index_reg <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      k_reg         <= '0;
      done_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      wrap_reg <= 1'b0;
      if (!abort) begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              idx_reg       <= start_index;
              remaining_reg <= num_points;
              acc_reg       <= '0;
              k_reg         <= '0;
            end
          end
          SEED: begin
            if (seed_last) begin
              out_data_reg  <= acc_reg;
              out_index_reg <= idx_reg;
            end else begin
              acc_reg <= acc_reg ^ ({(DIMS*WIDTH){g_bit}} & rd_data);
              k_reg   <= k_reg + 1'b1;
            end
          end
          RUN: begin
            if (handshake) begin
              if (lsz.all_ones) begin
                // gray(0) is zero, so every coordinate restarts at 0.
                out_data_reg  <= '0;
                out_index_reg <= '0;
                wrap_reg      <= 1'b1;
              end else begin
                out_data_reg  <= out_data_reg ^ rd_data;
                out_index_reg <= out_index_reg + 1'b1;
              end
              // A zero count means the run is unbounded.
              if (remaining_reg != '0) begin
                remaining_reg <= remaining_reg - 1'b1;
                if (last_point) begin
                  done_reg <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = (state_reg == RUN);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;
  assign out_index = out_index_reg;
  assign done      = done_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_sobol_multidim_gen.sv
// Scoreboard bench for sobol_multidim_gen (WIDTH=32, DIMS=2).
module tb_sobol_multidim_gen;

  localparam int W = 32;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   start_index = '0;
  logic [W-1:0]   num_points = '0;
  logic           dv_we = 1'b0;
  logic [0:0]     dv_dim = '0;
  logic [4:0]     dv_bit = '0;
  logic [W-1:0]   dv_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [D*W-1:0] out_data;
  logic [W-1:0]   out_index;
  logic           busy;
  logic           done;
  logic           wrap;

  sobol_multidim_gen #(.WIDTH(W), .DIMS(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .start_index (start_index),
    .num_points  (num_points),
    .dv_we       (dv_we),
    .dv_dim      (dv_dim),
    .dv_bit      (dv_bit),
    .dv_data     (dv_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .busy        (busy),
    .done        (done),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   idx;
    logic [D*W-1:0] data;
  } pt_t;

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] mv [D][W];
  pt_t exp_q[$];
  pt_t cap_q[$];

  // Reference: XOR of V[d][k] over the set bits of gray(n).
  function automatic logic [W-1:0] model_pt(input int d, input logic [W-1:0] n);
    logic [W-1:0] g;
    logic [W-1:0] acc;
    g = n ^ (n >> 1);
    acc = '0;
    for (int k = 0; k < W; k++) begin
      if (g[k]) acc = acc ^ mv[d][k];
    end
    return acc;
  endfunction

  // Scoreboard: every accepted point is captured and checked against the queue.
  always @(negedge clk) begin : mon
    pt_t got;
    pt_t e;
    if (rst_n && out_valid && out_ready) begin
      got.idx  = out_index;
      got.data = out_data;
      cap_q.push_back(got);
      $display("pt idx=%h d0=%h d1=%h", out_index, out_data[31:0], out_data[63:32]);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected idx=%h data=%h (no point expected)", got.idx, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) $display("FAIL sb_point got idx=%h data=%h exp idx=%h data=%h", got.idx, got.data, e.idx, e.data);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [W-1:0] si, input logic [W-1:0] np, input int npush);
    pt_t p;
    step();
    start_index = si;
    num_points  = np;
    start       = 1'b1;
    cap_q.delete();
    for (int i = 0; i < npush; i++) begin
      p.idx  = si + W'(i);
      p.data = {model_pt(1, p.idx), model_pt(0, p.idx)};
      exp_q.push_back(p);
    end
    step();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int limit, output int cycles, output int dones, output int wraps);
    cycles = 0;
    dones  = 0;
    wraps  = 0;
    do begin
      step();
      cycles++;
      if (done) dones++;
      if (wrap) wraps++;
    end while (busy && cycles < limit);
    repeat (3) begin
      step();
      if (done) dones++;
      if (wrap) wraps++;
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < D; d++)
      for (int k = 0; k < W; k++) mv[d][k] = W'(1) << (W - 1 - k);
    rst_n = 1'b0;
    repeat (3) step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if ({done, wrap} !== 2'b00) $display("FAIL reset_pulses got=%b exp=00", {done, wrap}); else n_pass++;
    n_total++; if ({out_data, out_index} !== '0) $display("FAIL reset_data got=%h/%h exp=0", out_data, out_index); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_default_run();
    logic [W-1:0] d0_exp [5];
    int cyc, cycles, dones, wraps;
    d0_exp = '{32'h0, 32'h80000000, 32'hC0000000, 32'h40000000, 32'h60000000};
    out_ready = 1'b1;
    kick(32'd0, 32'd5, 5);
    n_total++; if (out_valid !== 1'b0) $display("FAIL early_valid got=%b exp=0", out_valid); else n_pass++;
    wait_valid(100, cyc);
    n_total++; if (cyc != W + 1) $display("FAIL seed_latency got=%0d exp=%0d", cyc, W + 1); else n_pass++;
    run_until_idle(200, cycles, dones, wraps);
    n_total++; if (dones != 1) $display("FAIL default_done got=%0d exp=1", dones); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL default_left got=%0d exp=0", exp_q.size()); else n_pass++;
    n_total++; if (cap_q.size() != 5) $display("FAIL default_count got=%0d exp=5", cap_q.size()); else n_pass++;
    if (cap_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        n_total++;
        if (cap_q[i].data[31:0] !== d0_exp[i] || cap_q[i].idx !== W'(i))
          $display("FAIL default_dim0[%0d] got=%h@%h exp=%h@%h", i, cap_q[i].data[31:0], cap_q[i].idx, d0_exp[i], W'(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_dv_load();
    logic [W-1:0] vals [4];
    logic [W-1:0] d1_exp [5];
    logic [W-1:0] d0_exp [5];
    int cycles, dones, wraps;
    vals   = '{32'h80000000, 32'hC0000000, 32'hA0000000, 32'hF0000000};
    d1_exp = '{32'h0, 32'h80000000, 32'h40000000, 32'hC0000000, 32'h60000000};
    d0_exp = '{32'h0, 32'h80000000, 32'hC0000000, 32'h40000000, 32'h60000000};
    for (int i = 0; i < 4; i++) begin
      step();
      dv_we   = 1'b1;
      dv_dim  = 1'b1;
      dv_bit  = 5'(i);
      dv_data = vals[i];
      mv[1][i] = vals[i];
    end
    step();
    dv_we = 1'b0;
    kick(32'd0, 32'd5, 5);
    run_until_idle(200, cycles, dones, wraps);
    n_total++; if (dones != 1) $display("FAIL load_done got=%0d exp=1", dones); else n_pass++;
    n_total++; if (cap_q.size() != 5) $display("FAIL load_count got=%0d exp=5", cap_q.size()); else n_pass++;
    if (cap_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        n_total++;
        if (cap_q[i].data !== {d1_exp[i], d0_exp[i]})
          $display("FAIL load_point[%0d] got=%h exp=%h", i, cap_q[i].data, {d1_exp[i], d0_exp[i]});
        else n_pass++;
      end
    end
  endtask

  task automatic test_seek();
    int cycles, dones, wraps;
    kick(32'd4, 32'd1, 1);
    run_until_idle(200, cycles, dones, wraps);
    n_total++; if (dones != 1) $display("FAIL seek_done got=%0d exp=1", dones); else n_pass++;
    n_total++; if (cap_q.size() != 1) $display("FAIL seek_count got=%0d exp=1", cap_q.size()); else n_pass++;
    if (cap_q.size() == 1) begin
      n_total++;
      if (cap_q[0].idx !== 32'd4 || cap_q[0].data !== {32'h60000000, 32'h60000000})
        $display("FAIL seek_point got=%h@%h exp=%h@4", cap_q[0].data, cap_q[0].idx, {32'h60000000, 32'h60000000});
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int cyc, cycles, dones, wraps, stall_bad;
    logic [D*W-1:0] hold_d;
    logic [W-1:0]   hold_i;
    kick(32'd0, 32'd8, 8);
    wait_valid(100, cyc);
    repeat (3) step();
    out_ready = 1'b0;
    hold_d = out_data;
    hold_i = out_index;
    stall_bad = 0;
    repeat (7) begin
      step();
      if (out_data !== hold_d || out_index !== hold_i || out_valid !== 1'b1) stall_bad++;
    end
    n_total++; if (hold_i !== 32'd3) $display("FAIL bp_index got=%h exp=3", hold_i); else n_pass++;
    n_total++; if (stall_bad != 0) $display("FAIL bp_stable got=%0d changes exp=0", stall_bad); else n_pass++;
    out_ready = 1'b1;
    run_until_idle(200, cycles, dones, wraps);
    n_total++; if (cap_q.size() != 8) $display("FAIL bp_count got=%0d exp=8", cap_q.size()); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL bp_done got=%0d exp=1", dones); else n_pass++;
  endtask

  task automatic test_wrap();
    int cycles, dones, wraps;
    kick(32'hFFFFFFFF, 32'd2, 2);
    run_until_idle(200, cycles, dones, wraps);
    n_total++; if (wraps != 1) $display("FAIL wrap_pulses got=%0d exp=1", wraps); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL wrap_done got=%0d exp=1", dones); else n_pass++;
    n_total++; if (cap_q.size() != 2) $display("FAIL wrap_count got=%0d exp=2", cap_q.size()); else n_pass++;
    if (cap_q.size() == 2) begin
      n_total++;
      if (cap_q[0].idx !== 32'hFFFFFFFF || cap_q[1].idx !== 32'd0 || cap_q[1].data !== '0)
        $display("FAIL wrap_points got=%h,%h/%h exp=ffffffff,0/0", cap_q[0].idx, cap_q[1].idx, cap_q[1].data);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int cyc, cycles, dones, wraps, vals_seen;
    // Abort during the seed phase.
    kick(32'd0, 32'd3, 3);
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_total++; if ({busy, out_valid} !== 2'b00) $display("FAIL abort_seed got=%b exp=00", {busy, out_valid}); else n_pass++;
    exp_q.delete();
    dones = 0;
    vals_seen = 0;
    repeat (40) begin
      step();
      if (done) dones++;
      if (out_valid) vals_seen++;
    end
    n_total++; if (dones != 0 || vals_seen != 0) $display("FAIL abort_seed_quiet got done=%0d valid=%0d exp=0", dones, vals_seen); else n_pass++;
    // Abort during an unbounded run, with a table write attempted while running.
    kick(32'd0, 32'd0, 40);
    wait_valid(100, cyc);
    repeat (3) step();
    out_ready = 1'b0;
    dv_we   = 1'b1;
    dv_dim  = 1'b0;
    dv_bit  = 5'd0;
    dv_data = 32'h12345678;
    step();
    dv_we = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_total++; if ({busy, out_valid} !== 2'b00) $display("FAIL abort_run got=%b exp=00", {busy, out_valid}); else n_pass++;
    exp_q.delete();
    dones = 0;
    repeat (10) begin
      step();
      if (done) dones++;
    end
    n_total++; if (dones != 0) $display("FAIL abort_run_done got=%0d exp=0", dones); else n_pass++;
    // The table must be intact: the ignored write must not show up.
    out_ready = 1'b1;
    kick(32'd0, 32'd5, 5);
    run_until_idle(200, cycles, dones, wraps);
    n_total++; if (cap_q.size() != 5) $display("FAIL post_abort_count got=%0d exp=5", cap_q.size()); else n_pass++;
    if (cap_q.size() == 5) begin
      n_total++;
      if (cap_q[1].data[31:0] !== 32'h80000000) $display("FAIL post_abort_v0 got=%h exp=80000000", cap_q[1].data[31:0]);
      else n_pass++;
    end
    n_total++; if (dones != 1) $display("FAIL post_abort_done got=%0d exp=1", dones); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_dv_load();
    test_seek();
    test_backpressure();
    test_wrap();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
